imem_loader: RTL and testbench
==============================

# imem_loader

Writer side of the byte-addressable instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words (first byte received goes to the lowest address) and issues one word write per four bytes. It holds the core in reset until a load completes. It sits between the boot/debug byte source and the instruction memory write port; the fetch path keeps reading the memory as before.

## Interface
- `ADDR_W`, default 6: memory byte-address width; capacity is 2^ADDR_W bytes, or 2^(ADDR_W-2) words.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: load request; sampled only in IDLE.
- `num_words`  in  ADDR_W-1: words to load, latched on accepted `start`.
- `in_valid`  in  1: `in_data` valid.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `mem_we`  out  1: one-cycle word write strobe.
- `mem_addr`  out  ADDR_W: word-aligned byte address; bits [1:0] are always 0.
- `mem_wdata`  out  32: {byte3, byte2, byte1, byte0}, where byte0 is received first.
- `busy`  out  1: load in progress.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: checksum mismatch flag, sticky until next accepted `start`; constant 0 without the macro.
- `core_hold`  out  1: core reset request, active-high.

## Operation
- States:
  - IDLE: `in_ready`=0. On `start`=1:
    - latch count = min(`num_words`, 2^(ADDR_W-2)); word index=0; byte lane=0; clear `err`; set `core_hold`=1.
    - Go to RECV, or to FIN if count=0.
  - RECV: `in_ready`=1.
    - Each handshake (`in_valid`&`in_ready`) stores the byte in lane[1:0] and increments the lane.
    - The fourth byte moves to WRITE.
  - WRITE: `in_ready`=0; `mem_we`=1 with `mem_addr`=index*4 and the assembled word.
    - Increment index.
    - If index reaches count, go to FIN; else return to RECV with lane=0.
  - FIN: go to CHECK if the macro is defined; otherwise drive `done`=1, clear `core_hold`, go to IDLE.
  - CHECK (macro only): `in_ready`=1. On handshake, compare the byte with the checksum (see Configuration).
    - Set `err` on mismatch.
    - Drive `done`=1 next cycle; clear `core_hold` only when there is no error; go to IDLE.
- `busy`=1 in every state except IDLE.
- `start` is ignored outside IDLE.
- Bytes presented while `in_ready`=0 are not consumed; the source holds them.
- Word index arithmetic is modulo 2^(ADDR_W-2). Because of clamping, no wrap occurs within one load.
- `mem_wdata` and `mem_addr` hold their last values when `mem_we`=0.

## Timing
- Reset values (asynchronous): state IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, `core_hold`=1. Internal counters and lanes are 0.
- `core_hold` stays 1 after reset until the first successful `done`.
- `start` accepted at edge N: `busy`=1 and `in_ready`=1 from cycle N+1.
- Fourth byte handshake at edge M: `mem_we`=1 during cycle M+1; `in_ready` returns to 1 at cycle M+2. Minimum throughput is 5 cycles per word.
- Last write in cycle W: without the macro, `done`=1 in cycle W+2. `busy` deasserts together with `done`.
- `count`=0: `done` occurs 2 cycles after `start`, with no writes.
- Reset asserted mid-load aborts immediately:
  - no further `mem_we`;
  - partial word discarded;
  - memory keeps words already written;
  - `core_hold`=1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the payload, one extra byte is expected in CHECK.
  - The 8-bit sum of all payload bytes plus the checksum byte, modulo 256, must equal 0x00. Otherwise `err`=1 and `core_hold` remains 1.
- Undefined:
  - CHECK state and sum register are removed.
  - `err` is tied to 0.
  - FIN goes directly to `done`.

## Test plan
- Macro off, reset, `start` with `num_words`=1, bytes 33,03,94,00 sent back-to-back -> single `mem_we` with `mem_addr`=0 and `mem_wdata`=0x00940333; `done` 2 cycles later; `core_hold` falls.
- `num_words`=2, bytes 33,03,94,00,B3,83,29,41, with `in_valid` dropped for 3 cycles mid-word -> writes 0x00940333 @0 and 0x412983B3 @4; no extra writes.
- `start` pulsed during a load, and `num_words`=0 from IDLE -> the mid-load start is ignored; the count-0 load gives `done` with no `mem_we`.
- `num_words`=20 with `ADDR_W`=6 -> clamped to 16 writes at addresses 0..60; `done` afterwards.
- Macro on, payload 33,03,94,00 then checksum 36 -> `err`=0 and `core_hold` falls. Same payload with checksum 37 -> `err`=1, `done` pulses, `core_hold` stays 1.
- Reset asserted after 2 bytes of word 1 -> outputs at reset values immediately; after release, a fresh load behaves correctly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Bus interfaces for imem_loader: the incoming byte stream and the instruction-memory word-write port.

interface byte_stream_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

interface imem_wr_if #(parameter int ADDR_W = 6);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory word loader; holds the core in reset until a load completes.
// Optional trailing-checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.

module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-2:0] num_words,
    byte_stream_if.slave      in_bus,
    imem_wr_if.master         mem_bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              core_hold
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RECV  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] FIN   = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHECK = 3'd4;
`endif

    localparam logic [ADDR_W-2:0] WORD_CAP = {1'b1, {(ADDR_W-2){1'b0}}};
    localparam logic [ADDR_W-2:0] ZERO_W   = {(ADDR_W-1){1'b0}};
    localparam logic [ADDR_W-2:0] ONE_W    = {{(ADDR_W-2){1'b0}}, 1'b1};

    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    logic [2:0]        state_r;
    logic [ADDR_W-2:0] count_r;
    logic [ADDR_W-2:0] idx_r;
    logic [1:0]        lane_r;
    logic [23:0]       word_r;
    logic              in_ready_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              busy_r;
    logic              done_r;
    logic              hold_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_r;
    logic              err_r;
`endif

    logic              hs_s;
    logic [ADDR_W-2:0] idx_next_s;
    logic [ADDR_W-2:0] count_s;

    // Handshake, next word index and clamped word count.
    always_comb begin
        hs_s       = in_bus.in_valid & in_ready_r;
        idx_next_s = idx_r + ONE_W;
        if (num_words > WORD_CAP) begin
            count_s = WORD_CAP;
        end else begin
            count_s = num_words;
        end
    end

    // Load sequencer with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            count_r     <= ZERO_W;
            idx_r       <= ZERO_W;
            lane_r      <= 2'd0;
            word_r      <= 24'd0;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            hold_r      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_r       <= 8'd0;
            err_r       <= 1'b0;
`endif
        end else begin
            mem_we_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        count_r <= count_s;
                        idx_r   <= ZERO_W;
                        lane_r  <= 2'd0;
                        hold_r  <= 1'b1;
                        busy_r  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_r   <= 8'd0;
                        err_r   <= 1'b0;
`endif
                        if (count_s == ZERO_W) begin
                            state_r <= FIN;
                        end else begin
                            state_r    <= RECV;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (hs_s) begin
                        lane_r <= lane_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_r  <= sum8(sum_r, in_bus.in_data);
`endif
                        case (lane_r)
                            2'd0: word_r[7:0]   <= in_bus.in_data;
                            2'd1: word_r[15:8]  <= in_bus.in_data;
                            2'd2: word_r[23:16] <= in_bus.in_data;
                            default: begin
                                // Fourth byte goes straight into the write word.
                                mem_we_r    <= 1'b1;
                                mem_wdata_r <= {in_bus.in_data, word_r};
                                mem_addr_r  <= {idx_r[ADDR_W-3:0], 2'b00};
                                in_ready_r  <= 1'b0;
                                state_r     <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    idx_r  <= idx_next_s;
                    lane_r <= 2'd0;
                    if (idx_next_s == count_r) begin
                        state_r <= FIN;
                    end else begin
                        state_r    <= RECV;
                        in_ready_r <= 1'b1;
                    end
                end
                FIN: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_r    <= CHECK;
                    in_ready_r <= 1'b1;
`else
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    hold_r  <= 1'b0;
                    state_r <= IDLE;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (hs_s) begin
                        in_ready_r <= 1'b0;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                        if (sum8(sum_r, in_bus.in_data) != 8'd0) begin
                            err_r  <= 1'b1;
                            hold_r <= 1'b1;
                        end else begin
                            err_r  <= 1'b0;
                            hold_r <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_bus.in_ready   = in_ready_r;
    assign mem_bus.mem_we    = mem_we_r;
    assign mem_bus.mem_addr  = mem_addr_r;
    assign mem_bus.mem_wdata = mem_wdata_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign core_hold         = hold_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes/completions are queued at stimulus time
// and popped by an independent monitor sampling on the falling edge.
`timescale 1ns/1ps

module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int CAP    = 1 << (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-2:0] num_words = '0;
    logic              busy, done, err, core_hold;

    byte_stream_if               s_if ();
    imem_wr_if #(.ADDR_W(ADDR_W)) m_if ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .start     (start),
        .num_words (num_words),
        .in_bus    (s_if),
        .mem_bus   (m_if),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .core_hold (core_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic err;
        logic hold;
        bit   zero;
        int   start_cyc;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int done_seen = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       last_data = '0;
    logic [7:0]        pl[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT writes or completes.
    always @(negedge clk) begin
        wr_t e;
        dn_t d;
        if (rst_n) begin
            if (m_if.mem_we) begin
                last_we_cyc = cyc;
                chk("ready_low_in_write", 32'(s_if.in_ready), 32'd0);
                if (wq.size() == 0) begin
                    fail_now($sformatf("extra_write addr=%h data=%h", m_if.mem_addr, m_if.mem_wdata));
                end else begin
                    e = wq.pop_front();
                    chk("write_addr", 32'(m_if.mem_addr), 32'(e.addr));
                    chk("write_data", m_if.mem_wdata, e.data);
                end
                last_addr = m_if.mem_addr;
                last_data = m_if.mem_wdata;
            end else begin
                chk("addr_hold", 32'(m_if.mem_addr), 32'(last_addr));
                chk("data_hold", m_if.mem_wdata, last_data);
            end
            if (busy) chk("hold_while_busy", 32'(core_hold), 32'd1);
            if (done) begin
                done_seen++;
                chk("busy_at_done", 32'(busy), 32'd0);
                if (dq.size() == 0) begin
                    fail_now("extra_done");
                end else begin
                    d = dq.pop_front();
                    chk("err_at_done", 32'(err), 32'(d.err));
                    chk("hold_at_done", 32'(core_hold), 32'(d.hold));
`ifndef IMEM_LOADER_CHECKSUM_EN
                    if (d.zero) chk("done_lat_zero", 32'(cyc - d.start_cyc), 32'd2);
                    else        chk("done_lat", 32'(cyc - last_we_cyc), 32'd2);
`endif
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        s_if.in_valid = 1'b1;
        s_if.in_data  = b;
        while (s_if.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            fail_now("byte_timeout");
        end else begin
            @(negedge clk);
        end
        s_if.in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(s_if.in_ready), 32'd0);
        chk("rst_mem_we", 32'(m_if.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(m_if.mem_addr), 32'd0);
        chk("rst_mem_wdata", m_if.mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_core_hold", 32'(core_hold), 32'd1);
        s_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        wq.delete();
        dq.delete();
        last_addr = '0;
        last_data = '0;
        rst_n = 1'b1;
    endtask

    // cs: >=0 literal checksum byte, -1 correct checksum, -2 corrupted checksum.
    // gap_mode: 0 back-to-back, 1 random gaps, 2 three-cycle gap mid-word, 3 start pulse mid-load.
    task automatic do_load(input int n, input int cs, input int gap_mode, input int abort_at);
        int cnt;
        int ds0;
        int t;
        logic [7:0] sum;
        logic [7:0] csb;
        logic [7:0] tot;
        wr_t w;
        dn_t d;
        cnt = (n > CAP) ? CAP : n;
        while (pl.size() < cnt * 4) pl.push_back(8'($urandom));
        sum = 8'd0;
        for (int k = 0; k < cnt; k++) begin
            w.addr = ADDR_W'(k * 4);
            w.data = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
            wq.push_back(w);
            for (int j = 0; j < 4; j++) sum = sum + pl[4*k+j];
        end
        if (cs >= 0)       csb = 8'(cs);
        else if (cs == -1) csb = 8'd0 - sum;
        else               csb = 8'd1 - sum;
        tot = sum + csb;
`ifdef IMEM_LOADER_CHECKSUM_EN
        d.err  = (tot != 8'd0);
        d.hold = (tot != 8'd0);
`else
        d.err  = 1'b0;
        d.hold = 1'b0;
`endif
        d.zero = (cnt == 0);
        @(negedge clk);
        d.start_cyc = cyc;
        dq.push_back(d);
        ds0 = done_seen;
        start = 1'b1;
        num_words = (ADDR_W-1)'(n);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < cnt * 4; i++) begin
            if (i == abort_at) begin
                apply_reset();
                return;
            end
            send_byte(pl[i]);
            if (gap_mode == 1 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
            if (gap_mode == 2 && i == 5) repeat (3) @(negedge clk);
            if (gap_mode == 3 && i == 2) begin
                start = 1'b1;
                num_words = (ADDR_W-1)'($urandom_range(1, 3));
                @(negedge clk);
                start = 1'b0;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csb);
`endif
        t = 0;
        while (done_seen == ds0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (done_seen == ds0) fail_now("done_timeout");
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.in_valid = 1'b0;
        s_if.in_data  = 8'd0;
        apply_reset();

        pl = {8'h33, 8'h03, 8'h94, 8'h00};
        do_load(1, 8'h36, 0, -1);

        pl = {8'h33, 8'h03, 8'h94, 8'h00, 8'hB3, 8'h83, 8'h29, 8'h41};
        do_load(2, -1, 2, -1);

        pl.delete();
        do_load(3, -1, 3, -1);
        pl.delete();
        do_load(0, -1, 0, -1);

        pl.delete();
        do_load(20, -1, 1, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pl = {8'h33, 8'h03, 8'h94, 8'h00};
        do_load(1, 8'h37, 0, -1);
        chk("err_sticky", 32'(err), 32'd1);
        chk("hold_after_err", 32'(core_hold), 32'd1);
        pl = {8'h33, 8'h03, 8'h94, 8'h00};
        do_load(1, 8'h36, 0, -1);
        chk("err_cleared", 32'(err), 32'd0);
`endif

        pl.delete();
        do_load(2, -1, 0, 6);
        chk("hold_after_abort", 32'(core_hold), 32'd1);
        pl = {8'h33, 8'h03, 8'h94, 8'h00};
        do_load(1, 8'h36, 0, -1);
        chk("hold_after_reload", 32'(core_hold), 32'd0);

        repeat (6) begin
            pl.delete();
            do_load($urandom_range(0, 31), ($urandom_range(0, 2) == 0) ? -2 : -1, 1, -1);
        end

        repeat (10) @(negedge clk);
        chk("writes_pending", 32'(wq.size()), 32'd0);
        chk("dones_pending", 32'(dq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
